// File: rtl/nn_ctrl_pkg.sv
// Shared controller types for the NN datapath: sequencer states, bias select
// codes (also used by the bias mux) and the phase count.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_WB,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_HID0  = 2'b00;
  localparam logic [1:0] SEL_HID10 = 2'b01;
  localparam logic [1:0] SEL_HID20 = 2'b10;
  localparam logic [1:0] SEL_OUT   = 2'b11;

  localparam int NUM_PHASES = 4;
  localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

endpackage

// File: rtl/layer_phase_cnt.sv
// MAC operand counter for one phase; tc flags the last operand of the phase.
module layer_phase_cnt #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] last,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  // clr wins over en so an abort or phase end always leaves the counter at 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/layer_seq_ctrl.sv
// Sequences the shared MAC/bias datapath through three hidden groups and the
// output layer, handing each phase result downstream over wb_valid/wb_ready.
module layer_seq_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_HID = 30,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             wb_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       bias_sel,
  output logic             layer,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [IDX_W-1:0] in_idx,
  output logic             bias_add,
  output logic             wb_valid
);

  // Handshake: a phase result transfers on a cycle where wb_valid and
  // wb_ready are both high; wb_valid and bias_sel hold steady until then.

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] last;
  logic             tc;
  logic             cnt_en;
  logic             cnt_clr;

  assign last    = (phase_q == LAST_PHASE) ? IDX_W'(N_HID - 1) : IDX_W'(N_IN - 1);
  assign cnt_en  = (state_q == ST_MAC) && !tc;
  assign cnt_clr = (state_q != ST_MAC) || abort;

  layer_phase_cnt #(
    .IDX_W (IDX_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .last  (last),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_MAC;
        phase_d = SEL_HID0;
      end
    end else if (abort) begin
      // abort outranks wb_ready and the terminal count in the same cycle
      state_d = ST_IDLE;
      phase_d = SEL_HID0;
    end else begin
      case (state_q)
        ST_MAC: begin
          if (tc) begin
            state_d = ST_BIAS;
          end
        end
        ST_BIAS: begin
          state_d = ST_WB;
        end
        ST_WB: begin
          if (wb_ready) begin
            if (phase_q == LAST_PHASE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_MAC;
              phase_d = phase_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          phase_d = SEL_HID0;
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = SEL_HID0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= SEL_HID0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // bias_sel follows phase throughout, so the mux settles long before bias_add
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign bias_sel = phase_q;
  assign layer    = (phase_q == SEL_OUT);
  assign mac_en   = (state_q == ST_MAC);
  assign mac_clr  = (state_q == ST_MAC) && (cnt == '0);
  assign in_idx   = (state_q == ST_MAC) ? cnt : '0;
  assign bias_add = (state_q == ST_BIAS);
  assign wb_valid = (state_q == ST_WB);

endmodule
